// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the iterative ALU: 4-bit operation codes,
//            the controller state encoding and small op-classification
//            helpers used by the top level and the iterative datapath.
// Ports    : (package - no ports)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Division-family ops share the restoring-divide datapath.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // Ops that take WIDTH cycles in the iterative unit.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || is_div_op(op);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter_unit
// Purpose  : Shared iterative datapath. Multiply is shift-add, one partial
//            product per step, LSB first. Divide is restoring, one quotient
//            bit per step, MSB first. Both take exactly WIDTH steps.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_start           - load operands, clear accumulator/counter
//            i_op_div          - 1: divide, 0: multiply (sampled at start)
//            i_step            - perform one iteration this cycle
//            i_a, i_b          - operands (sampled at start)
//            o_quot_or_prod    - quotient/product AFTER the current step
//            o_rem             - remainder AFTER the current step
//            o_last            - current step is the final one
// Revision : 1.0 - initial release
// ============================================================================
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_op_div,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_quot_or_prod,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_last
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // r_acc  : product accumulator (mul) / partial remainder (div)
  // r_shift: multiplier bits consumed LSB first (mul) /
  //          dividend shifted out MSB first while quotient shifts in (div)
  // r_b    : multiplicand shifted left each step (mul) / divisor (div)
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op_div;

  logic [WIDTH-1:0] w_mul_addend;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quot;

  always_comb begin
    w_mul_addend = r_shift[0] ? r_b : '0;
    w_mul_acc    = r_acc + w_mul_addend;
    // The shifted partial remainder is always < 2*divisor, so WIDTH+1 bits
    // hold it. A zero divisor never borrows, which naturally yields an
    // all-ones quotient and a remainder equal to the dividend.
    w_trial      = {r_acc, r_shift[WIDTH-1]} - {1'b0, r_b};
    w_ge         = ~w_trial[WIDTH];
    // When the trial borrows, the shifted value was < divisor, so its top
    // bit (r_acc MSB) is zero and dropping it is lossless.
    w_div_rem    = w_ge ? w_trial[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_shift[WIDTH-1]};
    w_div_quot   = {r_shift[WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_shift  <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_op_div <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_shift  <= i_a;
      r_b      <= i_b;
      r_cnt    <= '0;
      r_op_div <= i_op_div;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_op_div) begin
        r_acc   <= w_div_rem;
        r_shift <= w_div_quot;
      end else begin
        r_acc   <= w_mul_acc;
        r_shift <= r_shift >> 1;
        r_b     <= r_b << 1;
      end
    end
  end

  // Next-step values let the controller capture the result on the final
  // step's edge instead of spending an extra cycle.
  assign o_quot_or_prod = r_op_div ? w_div_quot : w_mul_acc;
  assign o_rem          = w_div_rem;
  assign o_last         = (r_cnt == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/alu_iterative.sv
`default_nettype none
// ============================================================================
// Module   : alu_iterative
// Purpose  : Multi-cycle ALU with valid/ready handshakes on request and
//            result sides. Logic/add/sub/compare complete in one cycle;
//            unsigned MUL/DIVU/REMU iterate WIDTH cycles in alu_iter_unit.
// Ports    : clk_i, rst_i      - clock, synchronous active-high reset
//            valid_i/ready_o   - request handshake (ready only in IDLE)
//            src1_i, src2_i    - operands A, B
//            ctrl_i            - 4-bit op code
//            valid_o/ready_i   - result handshake (valid only in DONE)
//            result_o          - registered result
//            zero_o, greater_o, overflow_o, div_zero_o - registered flags
// Revision : 1.0 - initial release
// ============================================================================
module alu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             greater_o,
  output logic             overflow_o,
  output logic             div_zero_o
);

  localparam int MSB = WIDTH - 1;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_greater;
  logic             r_overflow;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_start;
  logic             w_step;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_ovf;
  logic [WIDTH-1:0] w_qp;
  logic [WIDTH-1:0] w_rem;
  logic             w_last;
  logic [WIDTH-1:0] w_iter_result;

  assign w_accept = (r_state == S_IDLE) && valid_i;
  assign w_start  = w_accept && is_iter_op(ctrl_i);
  assign w_step   = (r_state == S_BUSY);

  // Single-cycle ops evaluated straight from the request inputs; only used
  // on the accept cycle.
  always_comb begin
    w_sum       = src1_i + src2_i;
    w_diff      = src1_i - src2_i;
    w_sc_result = '0;
    w_sc_ovf    = 1'b0;
    case (ctrl_i)
      OP_AND:  w_sc_result = src1_i & src2_i;
      OP_OR:   w_sc_result = src1_i | src2_i;
      OP_XOR:  w_sc_result = src1_i ^ src2_i;
      OP_NOR:  w_sc_result = ~(src1_i | src2_i);
      OP_ADD: begin
        w_sc_result = w_sum;
        w_sc_ovf    = (src1_i[MSB] == src2_i[MSB]) && (w_sum[MSB] != src1_i[MSB]);
      end
      OP_SUB: begin
        w_sc_result = w_diff;
        w_sc_ovf    = (src1_i[MSB] != src2_i[MSB]) && (w_diff[MSB] != src1_i[MSB]);
      end
      OP_SLTU: w_sc_result = WIDTH'(src1_i < src2_i);
      OP_SLT:  w_sc_result = WIDTH'($signed(src1_i) < $signed(src2_i));
      default: w_sc_result = '0;
    endcase
  end

  alu_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk            (clk_i),
    .rst            (rst_i),
    .i_start        (w_start),
    .i_op_div       (is_div_op(ctrl_i)),
    .i_step         (w_step),
    .i_a            (src1_i),
    .i_b            (src2_i),
    .o_quot_or_prod (w_qp),
    .o_rem          (w_rem),
    .o_last         (w_last)
  );

  assign w_iter_result = (r_op == OP_REMU) ? w_rem : w_qp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_greater  <= 1'b0;
      r_overflow <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= ctrl_i;
            r_greater <= (src1_i > src2_i);
            if (is_iter_op(ctrl_i)) begin
              // Flags that depend only on operands are settled now; the
              // result and zero flag follow on the final iteration.
              r_overflow <= 1'b0;
              r_div_zero <= is_div_op(ctrl_i) && (src2_i == '0);
              r_state    <= S_BUSY;
            end else begin
              r_result   <= w_sc_result;
              r_zero     <= (w_sc_result == '0);
              r_overflow <= w_sc_ovf;
              r_div_zero <= 1'b0;
              r_state    <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (w_last) begin
            r_result <= w_iter_result;
            r_zero   <= (w_iter_result == '0);
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o    = (r_state == S_IDLE);
  assign valid_o    = (r_state == S_DONE);
  assign result_o   = r_result;
  assign zero_o     = r_zero;
  assign greater_o  = r_greater;
  assign overflow_o = r_overflow;
  assign div_zero_o = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_iterative.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_iterative
// Purpose  : Self-checking bench for alu_iterative at WIDTH = 32: a table of
//            directed vectors with hand-computed results, flags and latency,
//            plus sequences for backpressure, reset mid-iteration, held
//            valid_i while busy, and a short randomised run against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_iterative;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  src1_i;
  logic [W-1:0]  src2_i;
  logic [3:0]    ctrl_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  result_o;
  logic          zero_o;
  logic          greater_o;
  logic          overflow_o;
  logic          div_zero_o;

  int passed = 0;
  int total  = 0;

  alu_iterative #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .ctrl_i     (ctrl_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .greater_o  (greater_o),
    .overflow_o (overflow_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  // flags packed as {zero, greater, overflow, div_zero}
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flags;
    int           lat;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at #1 after a posedge. Issues one request, waits for the result,
  // holds it for `gap` cycles, then hands it off.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int gap, output logic [W-1:0] res, output logic [3:0] flags,
                        output int lat);
    int guard;
    guard = 0;
    while (!ready_o && guard < 200) begin
      @(posedge clk_i); #1; guard++;
    end
    valid_i = 1'b1; ctrl_i = op; src1_i = a; src2_i = b;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk_i); #1; lat++;
    end
    res   = result_o;
    flags = {zero_o, greater_o, overflow_o, div_zero_o};
    repeat (gap) begin
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
  endtask

  function automatic logic [W+3:0] ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         o;
    logic         d;
    logic [2*W-1:0] p;
    r = '0; o = 1'b0; d = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ADD:  begin r = a + b; o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      OP_SUB:  begin r = a - b; o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      OP_SLTU: r = (a < b) ? 1 : 0;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      OP_MUL:  begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; end
      OP_DIVU: begin d = (b == 0); r = d ? '1 : a / b; end
      OP_REMU: begin d = (b == 0); r = d ? a : a % b; end
      default: r = '0;
    endcase
    return {r, (r == 0), (a > b), o, d};
  endfunction

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] first_res;
    logic [3:0]   flags;
    int           lat;
    int           seen;
    int           nvalid;

    vecs[0]  = '{OP_ADD,  32'd5,          32'd7,          32'd12,         4'b0000, 1};
    vecs[1]  = '{OP_ADD,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b0110, 1};
    vecs[2]  = '{OP_SUB,  32'd3,          32'd3,          32'd0,          4'b1000, 1};
    vecs[3]  = '{OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          4'b0100, 1};
    vecs[4]  = '{OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          4'b1100, 1};
    vecs[5]  = '{OP_MUL,  32'h0001_0000,  32'h0001_0001,  32'h0001_0000,  4'b0000, 33};
    vecs[6]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         4'b0100, 33};
    vecs[7]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          4'b0100, 33};
    vecs[8]  = '{OP_DIVU, 32'd9,          32'd0,          32'hFFFF_FFFF,  4'b0101, 33};
    vecs[9]  = '{OP_REMU, 32'd9,          32'd0,          32'd9,          4'b0101, 33};
    vecs[10] = '{OP_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  4'b0000, 1};
    vecs[11] = '{OP_OR,   32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0,  4'b0000, 1};
    vecs[12] = '{OP_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  4'b0000, 1};
    vecs[13] = '{OP_NOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h000F_000F,  4'b0000, 1};
    vecs[14] = '{OP_SUB,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  4'b0110, 1};
    vecs[15] = '{4'b1111, 32'd5,          32'd3,          32'd0,          4'b1100, 1};
    vecs[16] = '{OP_MUL,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          4'b0000, 33};
    vecs[17] = '{OP_DIVU, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  4'b0100, 33};
    vecs[18] = '{OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          4'b0100, 33};
    vecs[19] = '{OP_SLT,  32'd1,          32'hFFFF_FFFF,  32'd0,          4'b1000, 1};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    src1_i = '0; src2_i = '0; ctrl_i = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk_i);
    #1;
    check("reset ready_o", ready_o, 1);
    check("reset valid_o", valid_o, 0);
    check("reset result_o", result_o, 0);
    check("reset flags", {zero_o, greater_o, overflow_o, div_zero_o}, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // ---- directed table ----
    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, flags, lat);
      check($sformatf("vec%0d result", i), res, vecs[i].res);
      check($sformatf("vec%0d flags", i), flags, vecs[i].flags);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d release", i), {valid_o, ready_o}, 2'b01);
    end

    // ---- backpressure: result held while ready_i stays low ----
    valid_i = 1'b1; ctrl_i = OP_ADD; src1_i = 32'd20; src2_i = 32'd22;
    @(posedge clk_i); #1;
    valid_i = 1'b0; src1_i = '0; src2_i = '0;
    @(posedge clk_i); #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("hold%0d valid/result", i), {valid_o, ready_o, result_o}, {2'b10, 32'd42});
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check("hold release", {valid_o, ready_o}, 2'b01);

    // ---- reset during BUSY iteration 10 ----
    valid_i = 1'b1; ctrl_i = OP_DIVU; src1_i = 32'd1000; src2_i = 32'd3;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    check("midop busy", ready_o, 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("midop after reset", {ready_o, valid_o, result_o, zero_o, greater_o, overflow_o, div_zero_o},
          {2'b10, 32'd0, 4'b0000});
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) nvalid++;
      @(posedge clk_i); #1;
    end
    check("midop no stray valid", nvalid, 0);
    run_op(OP_ADD, 32'd2, 32'd3, 0, res, flags, lat);
    check("post-reset add result", res, 5);
    check("post-reset add latency", lat, 1);

    // ---- valid_i held while busy; ready_i high early ----
    valid_i = 1'b1; ready_i = 1'b1; ctrl_i = OP_MUL; src1_i = 32'd3; src2_i = 32'd4;
    @(posedge clk_i); #1;
    ctrl_i = OP_ADD; src1_i = 32'd10; src2_i = 32'd20;
    seen = 0; first_res = '0; res = '0;
    for (int i = 0; i < 100 && seen < 2; i++) begin
      if (valid_o) begin
        if (seen == 0) first_res = result_o;
        else res = result_o;
        seen++;
        if (seen == 2) valid_i = 1'b0;
      end
      if (seen < 2) begin
        @(posedge clk_i); #1;
      end
    end
    check("held valid count", seen, 2);
    check("held valid first (mul)", first_res, 12);
    check("held valid second (add)", res, 30);
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check("held valid idle", {valid_o, ready_o}, 2'b01);

    // ---- short randomised run against the model ----
    for (int i = 0; i < 24; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W+3:0] exp;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 4 == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
      exp = ref_model(op, a, b);
      run_op(op, a, b, $urandom_range(0, 3), res, flags, lat);
      check($sformatf("rand%0d op%0h a=%0h b=%0h", i, op, a, b), {res, flags}, exp);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_iterative.md
# alu_iterative

Parametrised, multi-cycle successor to the pipeline's single-cycle ALU. Single-cycle logic/add/sub/compare ops are kept, and iterative unsigned multiply, divide and remainder are added behind a valid/ready handshake on both sides. Operands are captured at accept, and the result is held until the consumer takes it. The block sits in the EX stage; the hazard unit stalls on `ready_o`/`valid_o`.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4.
- `clk_i`  in  1: clock. All logic is rising-edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `valid_i`  in  1: request valid.
- `ready_o`  out  1: block can accept a request. High only in IDLE.
- `src1_i`  in  WIDTH: operand A.
- `src2_i`  in  WIDTH: operand B.
- `ctrl_i`  in  4: operation code (see Operation).
- `valid_o`  out  1: result valid. High only in DONE.
- `ready_i`  in  1: consumer accepts the result.
- `result_o`  out  WIDTH: result. Registered.
- `zero_o`  out  1: `result_o == 0`.
- `greater_o`  out  1: captured src1 > src2, unsigned.
- `overflow_o`  out  1: signed overflow of ADD/SUB; 0 for all other ops.
- `div_zero_o`  out  1: DIVU/REMU issued with src2 = 0.

## Operation
- Accept occurs on a cycle with `valid_i && ready_o`. `src1_i`, `src2_i` and `ctrl_i` are captured on that cycle.
- Inputs are ignored when `ready_o` is low. There is no queueing.
- Ops:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 MUL: low WIDTH bits of the unsigned product.
  - 0100 XOR
  - 0101 NOR
  - 0110 SUB
  - 0111 SLTU: 1 if A < B unsigned, else 0.
  - 1000 SLT: signed compare.
  - 1001 DIVU: quotient.
  - 1010 REMU: remainder.
  - Any other code: result 0 (flags computed normally, overflow 0).
- Arithmetic is modulo 2^WIDTH.
  - ADD overflow: operands share a sign and the result sign differs.
  - SUB overflow: operand signs differ and the result sign differs from A.
- MUL is shift-add: 1 partial product per cycle, LSB first, WIDTH iterations.
- DIVU/REMU is restoring division: 1 quotient bit per cycle, MSB first, WIDTH iterations.
- Divide by zero: quotient is all-ones, remainder is A, `div_zero_o` = 1. The full WIDTH iterations still run; there is no early exit.
- Flags are registered with the result and held stable with it while `valid_o` is high.
- FSM:
  - IDLE: on accept of a single-cycle op, go to DONE; on accept of MUL/DIVU/REMU, go to BUSY with iteration counter = 0.
  - BUSY: counter increments each cycle. When counter = WIDTH−1, load the result and go to DONE.
  - DONE: hold outputs; on `ready_i`, go to IDLE.
- Reset (any state, including mid-BUSY) forces:
  - state IDLE, `ready_o` = 1 on the cycle after reset;
  - `valid_o`, `result_o`, `zero_o`, `greater_o`, `overflow_o` and `div_zero_o` all 0;
  - counter 0, in-flight operation discarded.

## Timing
- Single-cycle ops: accept at cycle N, `valid_o` high at N+1.
- MUL/DIVU/REMU: accept at N, `valid_o` high at N+1+WIDTH (33 cycles for WIDTH = 32).
- `valid_o` stays high and outputs stay stable until a cycle with `ready_i` high. `valid_o` drops the following cycle, and `ready_o` rises in that same cycle.
- Minimum spacing between accepts is 2 cycles (accept, DONE with `ready_i` high).
- `ready_o` is a pure function of state; there is no combinational path from `ready_i` or `valid_i` to any output.
- `ready_i` high before `valid_o` has no effect.
- `valid_i` held high while busy is not accepted until IDLE. The request accepted then uses the inputs present in that cycle.

## Structure
- Package `alu_pkg` holds:
  - localparams for the 4-bit op codes;
  - the state enum (IDLE, BUSY, DONE).
- Sub-module `alu_iter_unit` (parameter WIDTH) implements the shared shift-add / restore-subtract datapath.
  - Its registers are accumulator, shift register and counter of width $clog2(WIDTH)+1.
  - Controls: `start`, `op_div`, `step`; outputs: `quot_or_prod`, `rem`.
- The top level holds the FSM, the combinational single-cycle ops, the flag logic and the output registers.
- Expected size: about 250 RTL lines total.

## Test plan
- Reset: `rst_i` high for 2 cycles → all outputs 0 and `ready_o` = 1. Then ADD 5 + 7 → `valid_o` at N+1, result 12, `zero_o` 0, `greater_o` 0.
- Overflow: WIDTH = 32, ADD 0x7FFFFFFF + 1 → 0x80000000, `overflow_o` 1. SUB 3 − 3 → 0, `zero_o` 1, `overflow_o` 0.
- Compares: SLT 0xFFFFFFFF vs 1 → result 1; SLTU of the same operands → result 0, `greater_o` 1.
- Multi-cycle ops:
  - MUL 0x10000 × 0x10001 → 0x00010000 (truncated), `valid_o` exactly 33 cycles after accept.
  - DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
  - DIVU 9 / 0 → 0xFFFFFFFF, `div_zero_o` 1; REMU 9 / 0 → 9.
- Backpressure and reset mid-op:
  - Hold `ready_i` low for 5 cycles in DONE → outputs stable and `valid_o` high throughout.
  - Assert `rst_i` at BUSY iteration 10 → IDLE the next cycle with no `valid_o`. A new ADD then completes correctly.
- Randomised regression at WIDTH = 8 and 32: random ops and operands with random `ready_i` gaps → results match the reference model, and no accept occurs while `ready_o` is low.
